// File: rtl/shl_serial32.sv
// shl_serial32: serial left shift/rotate, one bit per clock, start/done handshake
module shl_serial32 #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic             rotate,
  input  logic             fill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [SHW-1:0] cnt;
  logic rot_q, fill_q, accept;
  assign accept = start && state != SHIFT;
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = (shamt == '0) ? DONE : SHIFT;
    else if (state == SHIFT) state_nxt = (cnt == SHW'(1)) ? DONE : SHIFT;
    else if (state == DONE) state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      rot_q  <= 1'b0;
      fill_q <= 1'b0;
      cout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sreg   <= a;
        cnt    <= shamt;
        rot_q  <= rotate;
        fill_q <= fill;
        cout   <= 1'b0;
      end else if (state == SHIFT) begin
        sreg <= {sreg[WIDTH-2:0], rot_q ? sreg[WIDTH-1] : fill_q};
        cout <= sreg[WIDTH-1];
        cnt  <= cnt - 1'b1;
      end
    end
  end
  assign busy   = state == SHIFT;
  assign done   = state == DONE;
  assign result = sreg;
endmodule
